// File: rtl/ecc_scalar_mult_ctrl.sv
// Sequencer for Q = k*P (Jacobian), MSB-first double-and-add.
// Owns the accumulator and drives the external doubling/add units over en/flag handshakes.
module ecc_scalar_mult_ctrl #(
    parameter int KW      = 256,
    parameter int CW      = 256,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [KW-1:0]   k,
    input  logic [CW-1:0]   px,
    input  logic [CW-1:0]   py,
    input  logic [CW-1:0]   pz,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [CW-1:0]   acc_x,
    output logic [CW-1:0]   acc_y,
    output logic [CW-1:0]   acc_z,
    output logic [CW-1:0]   base_x,
    output logic [CW-1:0]   base_y,
    output logic [CW-1:0]   base_z,
    output logic            dbl_en,
    input  logic            dbl_flag,
    input  logic [3*CW-1:0] dbl_res,
    output logic            add_en,
    input  logic            add_flag,
    input  logic [3*CW-1:0] add_res
);

    localparam int CNTW = $clog2(KW) + 1;
    localparam int WCW  = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(KW - 1);
    localparam logic [WCW-1:0]  WC_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0]  WC_MAX   = WCW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, FIN} state_t;

    state_t          state, state_n;
    logic [KW-1:0]   ks, ks_n;
    logic [CNTW-1:0] lz, lz_n;
    logic [CNTW-1:0] bits_left, bits_left_n;
    logic [WCW-1:0]  wc, wc_n;
    logic [CW-1:0]   acc_x_n, acc_y_n, acc_z_n;
    logic [CW-1:0]   base_x_n, base_y_n, base_z_n;
    logic            err_n, dbl_en_n, add_en_n;
    logic            dbl_take, add_take;

    // wc is zero only in the en cycle, so a flag arriving alongside its own en pulse is dropped
    assign dbl_take = (state == DBL) && (wc != '0) && dbl_flag;
    assign add_take = (state == ADD) && (wc != '0) && add_flag;

    always_comb begin
        state_n     = state;
        ks_n        = ks;
        lz_n        = lz;
        bits_left_n = bits_left;
        wc_n        = wc;
        err_n       = err;
        acc_x_n     = acc_x;
        acc_y_n     = acc_y;
        acc_z_n     = acc_z;
        base_x_n    = base_x;
        base_y_n    = base_y;
        base_z_n    = base_z;

        case (state)
            IDLE: begin
                if (start) begin
                    ks_n        = k;
                    lz_n        = '0;
                    bits_left_n = '0;
                    err_n       = 1'b0;
                    base_x_n    = px;
                    base_y_n    = py;
                    base_z_n    = pz;
                    if (k == '0) begin
                        acc_x_n = CW'(1);
                        acc_y_n = CW'(1);
                        acc_z_n = '0;
                        state_n = FIN;
                    end else begin
                        state_n = SCAN;
                    end
                end
            end
            SCAN: begin
                ks_n = {ks[KW-2:0], 1'b0};
                if (!ks[KW-1]) begin
                    lz_n = lz + 1'b1;
                end else begin
                    acc_x_n     = base_x;
                    acc_y_n     = base_y;
                    acc_z_n     = base_z;
                    bits_left_n = LAST_IDX - lz;
                    if (bits_left_n != '0) state_n = DBL;
                    else                   state_n = FIN;
                end
            end
            DBL: begin
                if (dbl_take) begin
                    acc_x_n     = dbl_res[CW-1:0];
                    acc_y_n     = dbl_res[2*CW-1:CW];
                    acc_z_n     = dbl_res[3*CW-1:2*CW];
                    ks_n        = {ks[KW-2:0], 1'b0};
                    bits_left_n = bits_left - 1'b1;
                    if (ks[KW-1])                state_n = ADD;
                    else if (bits_left_n != '0)  state_n = DBL;
                    else                         state_n = FIN;
                end else if (wc == WC_LAST) begin
                    err_n   = 1'b1;
                    state_n = FIN;
                end
            end
            ADD: begin
                if (add_take) begin
                    acc_x_n = add_res[CW-1:0];
                    acc_y_n = add_res[2*CW-1:CW];
                    acc_z_n = add_res[3*CW-1:2*CW];
                    if (bits_left != '0) state_n = DBL;
                    else                 state_n = FIN;
                end else if (wc == WC_LAST) begin
                    err_n   = 1'b1;
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // DBL can be re-entered from itself, so entry is "new state" or "flag just consumed"
        dbl_en_n = (state_n == DBL) && ((state != DBL) || dbl_take);
        add_en_n = (state_n == ADD) && ((state != ADD) || add_take);
        if (dbl_en_n || add_en_n) wc_n = '0;
        else if (wc != WC_MAX)    wc_n = wc + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ks        <= '0;
            lz        <= '0;
            bits_left <= '0;
            wc        <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbl_en    <= 1'b0;
            add_en    <= 1'b0;
            acc_x     <= '0;
            acc_y     <= '0;
            acc_z     <= '0;
            base_x    <= '0;
            base_y    <= '0;
            base_z    <= '0;
        end else begin
            state     <= state_n;
            ks        <= ks_n;
            lz        <= lz_n;
            bits_left <= bits_left_n;
            wc        <= wc_n;
            err       <= err_n;
            busy      <= (state_n == SCAN) || (state_n == DBL) || (state_n == ADD);
            done      <= (state_n == FIN);
            dbl_en    <= dbl_en_n;
            add_en    <= add_en_n;
            acc_x     <= acc_x_n;
            acc_y     <= acc_y_n;
            acc_z     <= acc_z_n;
            base_x    <= base_x_n;
            base_y    <= base_y_n;
            base_z    <= base_z_n;
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Self-checking bench for ecc_scalar_mult_ctrl with stub point units (3-cycle latency)
// and a scoreboard of expected results built from an independent double-and-add model.
module tb_ecc_scalar_mult_ctrl;

    localparam int KW      = 8;
    localparam int CW      = 16;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k = '0;
    logic [CW-1:0]   px = '0, py = '0, pz = '0;
    logic            busy, done, err, dbl_en, add_en;
    logic [CW-1:0]   acc_x, acc_y, acc_z, base_x, base_y, base_z;
    logic            dbl_flag, add_flag;
    logic            stub_dbl_flag = 1'b0, stub_add_flag = 1'b0;
    logic            inj_dbl_flag = 1'b0, inj_add_flag = 1'b0;
    logic [3*CW-1:0] dbl_res = '0, add_res = '0;
    logic            dbl_stub_on = 1'b1;

    assign dbl_flag = stub_dbl_flag | inj_dbl_flag;
    assign add_flag = stub_add_flag | inj_add_flag;

    ecc_scalar_mult_ctrl #(.KW(KW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst), .start(start), .k(k),
        .px(px), .py(py), .pz(pz),
        .busy(busy), .done(done), .err(err),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .base_x(base_x), .base_y(base_y), .base_z(base_z),
        .dbl_en(dbl_en), .dbl_flag(dbl_flag), .dbl_res(dbl_res),
        .add_en(add_en), .add_flag(add_flag), .add_res(add_res)
    );

    always #5 clk = ~clk;

    // Tagged stand-ins for the point arithmetic; only distinctness matters
    function automatic logic [3*CW-1:0] fdbl(input logic [3*CW-1:0] a);
        logic [CW-1:0] x, y, z;
        x = a[CW-1:0];
        y = a[2*CW-1:CW];
        z = a[3*CW-1:2*CW];
        return {z + 16'h0003, y + x, {x[CW-2:0], x[CW-1]} ^ 16'h1D00};
    endfunction

    function automatic logic [3*CW-1:0] fadd(input logic [3*CW-1:0] a, input logic [3*CW-1:0] b);
        logic [CW-1:0] x, y, z;
        x = a[CW-1:0] + b[CW-1:0] + 16'h0101;
        y = a[2*CW-1:CW] ^ {b[2*CW-2:CW], 1'b0};
        z = (a[3*CW-1:2*CW] + b[3*CW-1:2*CW]) ^ 16'h0040;
        return {z, y, x};
    endfunction

    // Stub units: flag exactly 3 cycles after the en cycle
    int              dbl_cnt = 0, add_cnt = 0;
    logic [3*CW-1:0] dbl_op = '0, add_op1 = '0, add_op2 = '0;

    always @(negedge clk) begin
        stub_dbl_flag = 1'b0;
        if (dbl_cnt > 0) begin
            dbl_cnt = dbl_cnt - 1;
            if (dbl_cnt == 0) begin
                stub_dbl_flag = 1'b1;
                dbl_res       = fdbl(dbl_op);
            end
        end
        if (dbl_en && dbl_stub_on) begin
            dbl_cnt = 3;
            dbl_op  = {acc_z, acc_y, acc_x};
        end
    end

    always @(negedge clk) begin
        stub_add_flag = 1'b0;
        if (add_cnt > 0) begin
            add_cnt = add_cnt - 1;
            if (add_cnt == 0) begin
                stub_add_flag = 1'b1;
                add_res       = fadd(add_op1, add_op2);
            end
        end
        if (add_en) begin
            add_cnt = 3;
            add_op1 = {acc_z, acc_y, acc_x};
            add_op2 = {base_z, base_y, base_x};
        end
    end

    // Running monitor, sampled 1 time unit after each rising edge
    int   cyc = 0, n_dbl = 0, n_add = 0, n_busy = 0, n_done = 0;
    int   last_dbl_cyc = 0, last_done_cyc = 0;
    logic ev_log [0:4095];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (dbl_en) begin
            ev_log[n_dbl + n_add] = 1'b0;
            n_dbl++;
            last_dbl_cyc = cyc;
        end
        if (add_en) begin
            ev_log[n_dbl + n_add] = 1'b1;
            n_add++;
        end
        if (busy) n_busy++;
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    typedef struct {
        logic [CW-1:0] x, y, z, bx;
        logic          e;
        int            nd, na, nbusy;
        logic [31:0]   seq;
    } exp_t;

    exp_t sb[$];
    int   passed = 0, failed = 0, total = 0;
    int   snap_dbl, snap_add, snap_busy, snap_ev;

    // Reference double-and-add; seq holds a leading 1 then one bit per pulse (0=dbl, 1=add)
    function automatic exp_t model(input logic [KW-1:0] kv, input logic [CW-1:0] x,
                                   input logic [CW-1:0] y, input logic [CW-1:0] z,
                                   input logic dbl_ok);
        exp_t            r;
        int              msb;
        logic [3*CW-1:0] a;
        msb     = -1;
        r.bx    = x;
        r.e     = 1'b0;
        r.nd    = 0;
        r.na    = 0;
        r.nbusy = 0;
        r.seq   = 32'd1;
        for (int i = 0; i < KW; i++) if (kv[i]) msb = i;
        if (msb < 0) begin
            r.x = 16'd1;
            r.y = 16'd1;
            r.z = 16'd0;
            return r;
        end
        a       = {z, y, x};
        r.nbusy = KW - msb;
        for (int i = msb - 1; i >= 0 && !r.e; i--) begin
            r.nd++;
            r.seq = {r.seq[30:0], 1'b0};
            if (!dbl_ok) begin
                r.e     = 1'b1;
                r.nbusy = r.nbusy + TIMEOUT;
            end else begin
                a       = fdbl(a);
                r.nbusy = r.nbusy + 4;
                if (kv[i]) begin
                    r.na++;
                    r.seq   = {r.seq[30:0], 1'b1};
                    a       = fadd(a, {z, y, x});
                    r.nbusy = r.nbusy + 4;
                end
            end
        end
        {r.z, r.y, r.x} = a;
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [KW-1:0] kv, input logic [CW-1:0] x,
                                 input logic [CW-1:0] y, input logic [CW-1:0] z,
                                 input logic dbl_ok);
        @(negedge clk);
        dbl_stub_on = dbl_ok;
        k         = kv;
        px        = x;
        py        = y;
        pz        = z;
        start     = 1'b1;
        snap_dbl  = n_dbl;
        snap_add  = n_add;
        snap_busy = n_busy;
        snap_ev   = n_dbl + n_add;
        sb.push_back(model(kv, x, y, z, dbl_ok));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int lat);
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checkVal({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t        e;
        logic [31:0] code;
        checkVal({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            code = 32'd1;
            for (int i = snap_ev; i < n_dbl + n_add; i++) code = {code[30:0], ev_log[i]};
            checkVal({tag, "_acc_x"},  64'(acc_x), 64'(e.x));
            checkVal({tag, "_acc_y"},  64'(acc_y), 64'(e.y));
            checkVal({tag, "_acc_z"},  64'(acc_z), 64'(e.z));
            checkVal({tag, "_base_x"}, 64'(base_x), 64'(e.bx));
            checkVal({tag, "_err"},    64'(err), 64'(e.e));
            checkVal({tag, "_n_dbl"},  64'(n_dbl - snap_dbl), 64'(e.nd));
            checkVal({tag, "_n_add"},  64'(n_add - snap_add), 64'(e.na));
            checkVal({tag, "_order"},  64'(code), 64'(e.seq));
            checkVal({tag, "_busy_cycles"}, 64'(n_busy - snap_busy), 64'(e.nbusy));
        end
        @(negedge clk);
        checkVal({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, w, done_snap;

        repeat (3) @(negedge clk);
        checkVal("reset_ctrl", 64'({busy, done, err, dbl_en, add_en}), 64'd0);
        checkVal("reset_acc",  64'({acc_x, acc_y, acc_z}), 64'd0);
        checkVal("reset_base", 64'({base_x, base_y, base_z}), 64'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: k=01, only scanning");
        applyStimulus(8'h01, 16'd5, 16'd7, 16'd1, 1'b1);
        waitDone("t1", lat);
        checkOutput("t1");

        $display("[TB] test 2: k=0B, D D A D A");
        applyStimulus(8'h0B, 16'h1234, 16'h5678, 16'h0001, 1'b1);
        waitDone("t2", lat);
        checkOutput("t2");

        $display("[TB] test 3: k=00, point at infinity");
        applyStimulus(8'h00, 16'h00AA, 16'h00BB, 16'h00CC, 1'b1);
        waitDone("t3", lat);
        checkVal("t3_done_latency", 64'(lat), 64'd0);
        checkOutput("t3");

        $display("[TB] test 4: k=03, doubling unit silent");
        applyStimulus(8'h03, 16'h0F0F, 16'h3C3C, 16'h0002, 1'b0);
        waitDone("t4", lat);
        checkVal("t4_timeout_distance", 64'(last_done_cyc - last_dbl_cyc), 64'(TIMEOUT));
        checkOutput("t4");
        applyStimulus(8'h05, 16'h0042, 16'h0099, 16'h0007, 1'b1);
        waitDone("t4b", lat);
        checkOutput("t4b");

        $display("[TB] test 5: stray start and flags during DBL");
        applyStimulus(8'h0B, 16'h1234, 16'h5678, 16'h0001, 1'b1);
        w = 0;
        while (!dbl_en && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkVal("t5_dbl_en_seen", 64'(dbl_en), 64'd1);
        inj_dbl_flag = 1'b1;
        @(negedge clk);
        inj_dbl_flag = 1'b0;
        inj_add_flag = 1'b1;
        start        = 1'b1;
        k            = 8'hFF;
        @(negedge clk);
        inj_add_flag = 1'b0;
        start        = 1'b0;
        k            = 8'h0B;
        waitDone("t5", lat);
        checkOutput("t5");

        $display("[TB] test 6: reset mid-ADD");
        applyStimulus(8'h0B, 16'h2222, 16'h4444, 16'h0003, 1'b1);
        w = 0;
        while (!add_en && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkVal("t6_add_en_seen", 64'(add_en), 64'd1);
        @(negedge clk);
        done_snap = n_done;
        nrst      = 1'b0;
        #1;
        checkVal("t6_reset_ctrl", 64'({busy, done, err, dbl_en, add_en}), 64'd0);
        checkVal("t6_reset_acc",  64'({acc_x, acc_y, acc_z}), 64'd0);
        checkVal("t6_reset_base", 64'({base_x, base_y, base_z}), 64'd0);
        sb.delete();
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("t6_stale_flag_busy", 64'(busy), 64'd0);
        checkVal("t6_stale_flag_done", 64'(n_done - done_snap), 64'd0);
        checkVal("t6_stale_flag_acc",  64'({acc_x, acc_y, acc_z}), 64'd0);
        applyStimulus(8'h0B, 16'h1234, 16'h5678, 16'h0001, 1'b1);
        waitDone("t6", lat);
        checkOutput("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
